// File: rtl/path_tracker.sv
// Tracks an object along a fixed closed path, counting accepted steps and completed laps.
// Illegal moves latch an error and park the tracker in LOST until the object is seen at home.
module path_tracker (
  input  logic       variable_clock,
  input  logic       rst,
  input  logic [6:0] var_x,
  input  logic [6:0] var_y,
  input  logic       clr_err,
  output logic [2:0] seg,
  output logic [7:0] step_count,
  output logic [7:0] lap_count,
  output logic       lap_pulse,
  output logic       abort_pulse,
  output logic       err_pulse,
  output logic       err_sticky
);

  typedef enum logic [2:0] {
    SegD0   = 3'd0,
    SegL1   = 3'd1,
    SegU2   = 3'd2,
    SegR3   = 3'd3,
    SegU4   = 3'd4,
    SegR5   = 3'd5,
    SegRet  = 3'd6,
    SegLost = 3'd7
  } seg_e;

  localparam logic [6:0] HomeX = 7'd84;
  localparam logic [6:0] HomeY = 7'd0;

  seg_e       r_seg;
  logic [7:0] r_step_count;
  logic [7:0] r_lap_count;
  logic       r_lap_pulse;
  logic       r_abort_pulse;
  logic       r_err_pulse;
  logic       r_err_sticky;
  logic [6:0] r_prev_x;
  logic [6:0] r_prev_y;

  logic [6:0] w_exp_x;
  logic [6:0] w_exp_y;
  logic [6:0] w_end_x;
  logic [6:0] w_end_y;
  logic       w_has_step;
  logic       w_home;
  logic       w_prev_home;
  logic       w_stall;
  logic       w_step;
  logic       w_at_end;
  logic       w_illegal;

  // Expected next position (prev plus unit step) and endpoint of the current segment.
  always_comb begin
    w_exp_x    = r_prev_x;
    w_exp_y    = r_prev_y;
    w_end_x    = HomeX;
    w_end_y    = HomeY;
    w_has_step = 1'b1;
    case (r_seg)
      SegD0: begin
        w_exp_y = r_prev_y + 7'd1;
        w_end_x = 7'd84;
        w_end_y = 7'd53;
      end
      SegL1: begin
        w_exp_x = r_prev_x - 7'd1;
        w_end_x = 7'd41;
        w_end_y = 7'd53;
      end
      SegU2: begin
        w_exp_y = r_prev_y - 7'd1;
        w_end_x = 7'd41;
        w_end_y = 7'd25;
      end
      SegR3: begin
        w_exp_x = r_prev_x + 7'd1;
        w_end_x = 7'd64;
        w_end_y = 7'd25;
      end
      SegU4: begin
        w_exp_y = r_prev_y - 7'd1;
        w_end_x = 7'd64;
        w_end_y = 7'd127;
      end
      SegR5: begin
        w_exp_x = r_prev_x + 7'd1;
        w_end_x = 7'd85;
        w_end_y = 7'd127;
      end
      default: w_has_step = 1'b0;
    endcase
  end

  assign w_home      = (var_x == HomeX) && (var_y == HomeY);
  assign w_prev_home = (r_prev_x == HomeX) && (r_prev_y == HomeY);
  assign w_stall     = (var_x == r_prev_x) && (var_y == r_prev_y);
  assign w_step      = w_has_step && (var_x == w_exp_x) && (var_y == w_exp_y);
  assign w_at_end    = (var_x == w_end_x) && (var_y == w_end_y);
  assign w_illegal   = !w_home && (r_seg != SegLost) && !w_stall && !w_step;

  always_ff @(posedge variable_clock or posedge rst) begin
    if (rst) begin
      r_seg         <= SegD0;
      r_step_count  <= 8'd0;
      r_lap_count   <= 8'd0;
      r_lap_pulse   <= 1'b0;
      r_abort_pulse <= 1'b0;
      r_err_pulse   <= 1'b0;
      r_err_sticky  <= 1'b0;
      r_prev_x      <= HomeX;
      r_prev_y      <= HomeY;
    end else begin
      r_prev_x      <= var_x;
      r_prev_y      <= var_y;
      r_lap_pulse   <= 1'b0;
      r_abort_pulse <= 1'b0;
      r_err_pulse   <= 1'b0;
      if (w_home) begin
        r_seg        <= SegD0;
        r_step_count <= 8'd0;
        if (r_seg == SegRet) begin
          r_lap_pulse <= 1'b1;
          if (r_lap_count != 8'hFF) r_lap_count <= r_lap_count + 8'd1;
        end else if (!w_prev_home) begin
          r_abort_pulse <= 1'b1;
        end
      end else if (w_step) begin
        if (r_step_count != 8'hFF) r_step_count <= r_step_count + 8'd1;
        if (w_at_end) r_seg <= seg_e'(r_seg + 3'd1);
      end else if (w_illegal) begin
        r_err_pulse <= 1'b1;
        r_seg       <= SegLost;
      end
      // Setting the error has priority over clearing it.
      if (w_illegal) r_err_sticky <= 1'b1;
      else if (clr_err) r_err_sticky <= 1'b0;
    end
  end

  assign seg         = r_seg;
  assign step_count  = r_step_count;
  assign lap_count   = r_lap_count;
  assign lap_pulse   = r_lap_pulse;
  assign abort_pulse = r_abort_pulse;
  assign err_pulse   = r_err_pulse;
  assign err_sticky  = r_err_sticky;

endmodule

// File: tb/tb_path_tracker.sv
// Scoreboard bench for path_tracker: the driver pushes modelled responses per sample,
// a monitor pops and compares them one clock later; directed checks cover key scenarios.
module tb_path_tracker;

  logic       clk;
  logic       rst;
  logic [6:0] var_x;
  logic [6:0] var_y;
  logic       clr_err;
  logic [2:0] seg;
  logic [7:0] step_count;
  logic [7:0] lap_count;
  logic       lap_pulse;
  logic       abort_pulse;
  logic       err_pulse;
  logic       err_sticky;

  path_tracker dut (
    .variable_clock(clk),
    .rst           (rst),
    .var_x         (var_x),
    .var_y         (var_y),
    .clr_err       (clr_err),
    .seg           (seg),
    .step_count    (step_count),
    .lap_count     (lap_count),
    .lap_pulse     (lap_pulse),
    .abort_pulse   (abort_pulse),
    .err_pulse     (err_pulse),
    .err_sticky    (err_sticky)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0] seg;
    logic [7:0] step;
    logic [7:0] lap;
    logic       lp;
    logic       ap;
    logic       ep;
    logic       es;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_err    = 0;
  int   lap_pulses = 0;

  // Path description: waypoint s is the start of segment s; unit step per segment.
  int wpx [7] = '{84, 84, 41, 41, 64, 64, 85};
  int wpy [7] = '{0, 53, 53, 25, 25, 127, 127};
  int ddx [6] = '{0, -1, 0, 1, 0, 1};
  int ddy [6] = '{1, 0, -1, 0, -1, 0};

  // Reference model state
  int         m_seg;
  logic [7:0] m_step;
  logic [7:0] m_lap;
  logic [6:0] m_px;
  logic [6:0] m_py;
  logic       m_es;

  // Walker position along the legal path
  logic [6:0] cur_x;
  logic [6:0] cur_y;
  int         cur_s;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_seg = 0; m_step = 0; m_lap = 0; m_px = 7'd84; m_py = 7'd0; m_es = 1'b0;
    cur_x = 7'd84; cur_y = 7'd0; cur_s = 0;
  endtask

  task automatic model_step(input logic [6:0] x, input logic [6:0] y, input logic clr,
                            output exp_t e);
    logic lp, ap, ep;
    logic [6:0] nx, ny;
    lp = 0; ap = 0; ep = 0;
    if (x == 7'd84 && y == 7'd0) begin
      if (m_seg == 6) begin
        lp = 1;
        if (m_lap != 8'd255) m_lap = m_lap + 8'd1;
      end else if (!(m_px == 7'd84 && m_py == 7'd0)) begin
        ap = 1;
      end
      m_seg = 0; m_step = 0;
    end else if (m_seg == 7) begin
      // ignored while lost
    end else if (x == m_px && y == m_py) begin
      // stall
    end else begin
      if (m_seg < 6) begin
        nx = m_px + 7'(ddx[m_seg]);
        ny = m_py + 7'(ddy[m_seg]);
      end
      if (m_seg < 6 && x == nx && y == ny) begin
        if (m_step != 8'd255) m_step = m_step + 8'd1;
        if (int'(x) == wpx[m_seg+1] && int'(y) == wpy[m_seg+1]) m_seg = m_seg + 1;
      end else begin
        ep = 1; m_seg = 7;
      end
    end
    if (ep) m_es = 1'b1;
    else if (clr) m_es = 1'b0;
    m_px = x; m_py = y;
    e.seg = 3'(m_seg); e.step = m_step; e.lap = m_lap;
    e.lp = lp; e.ap = ap; e.ep = ep; e.es = m_es;
  endtask

  task automatic drive(input logic [6:0] x, input logic [6:0] y, input logic clr = 1'b0);
    exp_t e;
    @(negedge clk);
    var_x = x; var_y = y; clr_err = clr;
    model_step(x, y, clr, e);
    q.push_back(e);
  endtask

  task automatic walk(input int n);
    for (int i = 0; i < n; i++) begin
      cur_x = cur_x + 7'(ddx[cur_s]);
      cur_y = cur_y + 7'(ddy[cur_s]);
      if (int'(cur_x) == wpx[cur_s+1] && int'(cur_y) == wpy[cur_s+1]) cur_s++;
      drive(cur_x, cur_y);
    end
  endtask

  task automatic go_home(input logic clr = 1'b0);
    drive(7'd84, 7'd0, clr);
    cur_x = 7'd84; cur_y = 7'd0; cur_s = 0;
  endtask

  task automatic do_lap();
    walk(194);
    go_home();
  endtask

  task automatic settle();
    @(posedge clk);
    #2;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_seg"}, 32'(seg), 0);
    check({tag, "_step"}, 32'(step_count), 0);
    check({tag, "_lap"}, 32'(lap_count), 0);
    check({tag, "_pulses"}, 32'({lap_pulse, abort_pulse, err_pulse}), 0);
    check({tag, "_sticky"}, 32'(err_sticky), 0);
  endtask

  // Monitor: one response per sample, presented one clock after it.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        check("sb_seg", 32'(seg), 32'(e.seg));
        check("sb_step", 32'(step_count), 32'(e.step));
        check("sb_lap", 32'(lap_count), 32'(e.lap));
        check("sb_lap_pulse", 32'(lap_pulse), 32'(e.lp));
        check("sb_abort_pulse", 32'(abort_pulse), 32'(e.ap));
        check("sb_err_pulse", 32'(err_pulse), 32'(e.ep));
        check("sb_err_sticky", 32'(err_sticky), 32'(e.es));
        check("sb_pulse_excl", 32'((32'(lap_pulse) + 32'(abort_pulse) + 32'(err_pulse)) <= 1), 1);
        if (lap_pulse) lap_pulses++;
      end
    end
  end

  initial begin
    rst = 1'b1; var_x = 7'd84; var_y = 7'd0; clr_err = 1'b0;
    model_reset();
    #1;
    check_all_zero("reset_init");
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Idle at home
    repeat (3) go_home();

    // Full lap
    lap_pulses = 0;
    do_lap();
    settle();
    check("lap_count_1", 32'(lap_count), 1);
    check("lap_pulse_once", 32'(lap_pulses), 1);
    check("lap_err_sticky", 32'(err_sticky), 0);
    check("lap_seg_home", 32'(seg), 0);

    // Wrap through y=0 in U4
    walk(171);
    settle();
    check("wrap_seg_u4", 32'(seg), 4);
    walk(2);
    settle();
    check("wrap_seg_r5", 32'(seg), 5);
    check("wrap_step", 32'(step_count), 173);
    check("wrap_no_err", 32'(err_sticky), 0);
    go_home();

    // Stall then jump
    walk(10);
    repeat (5) drive(7'd84, 7'd10);
    settle();
    check("stall_step", 32'(step_count), 10);
    check("stall_no_pulse", 32'({lap_pulse, abort_pulse, err_pulse}), 0);
    drive(7'd84, 7'd12);
    settle();
    check("jump_err_pulse", 32'(err_pulse), 1);
    check("jump_seg_lost", 32'(seg), 7);
    check("jump_sticky", 32'(err_sticky), 1);
    check("jump_step_kept", 32'(step_count), 10);
    drive(7'd10, 7'd10);
    settle();
    check("lost_no_err_pulse", 32'(err_pulse), 0);
    go_home();
    settle();
    check("lost_abort", 32'(abort_pulse), 1);
    check("lost_exit_seg", 32'(seg), 0);
    check("lost_lap_kept", 32'(lap_count), 1);

    // Clear, then clear coinciding with an error
    go_home(1'b1);
    settle();
    check("clr_sticky", 32'(err_sticky), 0);
    walk(1);
    drive(7'd84, 7'd5, 1'b1);
    settle();
    check("clr_vs_set_pulse", 32'(err_pulse), 1);
    check("clr_vs_set_sticky", 32'(err_sticky), 1);
    go_home();
    go_home(1'b1);

    // Abort mid-path at (41,40)
    walk(109);
    go_home();
    settle();
    check("abort_pulse", 32'(abort_pulse), 1);
    check("abort_step", 32'(step_count), 0);
    check("abort_no_lap", 32'(lap_pulse), 0);

    // Asynchronous reset mid-lap
    walk(60);
    @(posedge clk);
    #3;
    rst = 1'b1; var_x = 7'd84; var_y = 7'd0; clr_err = 1'b0;
    #1;
    check_all_zero("reset_mid");
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    walk(1);
    settle();
    check("post_reset_step", 32'(step_count), 1);
    check("post_reset_seg", 32'(seg), 0);
    check("post_reset_err", 32'(err_sticky), 0);
    go_home();

    // Lap counter saturation
    repeat (256) do_lap();
    settle();
    check("lap_saturate", 32'(lap_count), 255);

    repeat (2) @(posedge clk);
    #3;
    check("queue_drained", 32'(q.size()), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/path_tracker.md
PATH_TRACKER -- requirements
Module: path_tracker

Interface
REQ-001 The block SHALL have these ports, in this order (name, direction, width, meaning):
- variable_clock, in, 1: sole clock; all state updates on its rising edge.
- rst, in, 1: asynchronous, active-high reset.
- var_x, in, 7: observed object X coordinate, sampled every clock.
- var_y, in, 7: observed object Y coordinate, sampled every clock.
- clr_err, in, 1: synchronous clear of err_sticky.
- seg, out, 3: current path segment code.
- step_count, out, 8: accepted steps since the last home sample.
- lap_count, out, 8: completed laps, saturating.
- lap_pulse, out, 1: one-cycle strobe when a lap completes.
- abort_pulse, out, 1: one-cycle strobe when the object returns home early.
- err_pulse, out, 1: one-cycle strobe on an illegal move.
- err_sticky, out, 1: latched error flag.

Function
REQ-002 Segment codes SHALL be: D0=0, L1=1, U2=2, R3=3, U4=4, R5=5, RET=6, LOST=7.
REQ-003 The legal path SHALL be, with the endpoint of each segment also being the start of the next:
- D0: x=84, y+1 per step, from 0 to 53.
- L1: y=53, x-1 per step, from 84 to 41.
- U2: x=41, y-1 per step, from 53 to 25.
- R3: y=25, x+1 per step, from 41 to 64.
- U4: x=64, y-1 per step, from 25 to 127 (passes through 0, then wraps mod 128).
- R5: y=127, x+1 per step, from 64 to 85.
- RET: next sample is (84,0).
REQ-004 All coordinate arithmetic SHALL be 7-bit modulo-128.
REQ-005 The block SHALL hold registered prev_x/prev_y. Each cycle it SHALL update them to the current sample.
REQ-006 Home sample (84,0), evaluated with priority over all other cases:
- seg=RET: lap_count+1 (saturate at 255), lap_pulse=1, step_count=0, seg=D0.
- prev=(84,0): idle hold, no pulses, seg=D0, step_count=0.
- otherwise: abort_pulse=1, step_count=0, seg=D0, lap_count unchanged.
REQ-007 Stall (sample == prev, not home) SHALL be legal: no pulse, seg and step_count unchanged.
REQ-008 Accepted step: the sample equals prev plus the current segment's unit step.
- step_count SHALL increment, saturating at 255.
- If the sample equals the segment endpoint, seg SHALL advance to the next code in the same cycle.
REQ-009 Any other non-home sample in D0..RET SHALL be illegal:
- err_pulse=1, err_sticky=1, seg=LOST, step_count unchanged.
REQ-010 In LOST, every non-home sample SHALL be ignored with no further err_pulse. Exit from LOST is by a home sample only: abort_pulse=1, seg=D0.
REQ-011 A full legal lap SHALL be 195 accepted steps: 53+43+28+23+26+21 plus the return step. lap_pulse SHALL assert on the clock edge that samples (84,0) after (85,127).
REQ-012 clr_err=1 SHALL clear err_sticky next edge. If an err_pulse occurs in the same cycle, set SHALL win.
REQ-013 All pulses SHALL be registered, one cycle wide, and never asserted simultaneously.
REQ-014 Latency: outputs SHALL reflect a sample one clock after that sample is presented.

Reset
REQ-015 While rst=1, asynchronously:
- seg=D0; step_count=0; lap_count=0.
- all pulses 0; err_sticky=0.
- prev=(84,0).
REQ-016 Reset asserted mid-lap SHALL discard progress. The first post-reset non-home sample SHALL be judged against prev=(84,0).

Verification
REQ-017 Reset: assert rst mid-operation -> all outputs zero and seg=0 immediately, without waiting for a clock edge.
REQ-018 Full lap: drive the exact 195-step sequence from (84,0) -> seg steps 0..6, then 0; lap_pulse exactly once; lap_count=1; err_sticky=0.
REQ-019 Wrap: in U4 drive (64,1),(64,0),(64,127) -> no error; seg=R5 after (64,127).
REQ-020 Stall and jump:
- Hold (84,10) for 5 cycles -> step_count stays 10, no pulse.
- Then drive (84,12) -> err_pulse=1, seg=7, err_sticky=1.
- Then drive (84,0) -> abort_pulse=1, seg=0, lap_count unchanged.
REQ-021 Abort: legal path to (41,40), then (84,0) -> abort_pulse=1, step_count=0, no lap_pulse.
REQ-022 Saturation and clear:
- 256 legal laps -> lap_count=255.
- clr_err coinciding with err_pulse -> err_sticky remains 1.
